// File: rtl/ac97_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ac97_cmd_sequencer
// Brief    : AC97 control-slot scheduler: codec init writes, then round-robin
//            between volume updates and an external register-write port.
//            Optional macro AC97_VOL_DEBOUNCE_EN adds frame-based volume debounce.
// Revision : 1.0
// ============================================================================
module ac97_cmd_sequencer #(
  parameter logic [4:0] PCMOUT_GAIN = 5'b01000
`ifdef AC97_VOL_DEBOUNCE_EN
  , parameter int DEBOUNCE_FRAMES = 4
`endif
) (
  input  logic        bit_clk,
  input  logic        reset_b,
  input  logic        frame_start,
  input  logic        codec_ready,
  input  logic [3:0]  volume_control,
  input  logic        ext_req,
  input  logic [6:0]  ext_addr,
  input  logic [15:0] ext_data,
  output logic        ext_ack,
  output logic        cmd_valid,
  output logic [19:0] cmd_addr,
  output logic [19:0] cmd_data,
  output logic        init_done
);

  // Post-init states all have bit 2 set; init_done is decoded from that.
  localparam logic [2:0] ST_WAIT_READY  = 3'd0;
  localparam logic [2:0] ST_INIT_MASTER = 3'd1;
  localparam logic [2:0] ST_INIT_HEADPH = 3'd2;
  localparam logic [2:0] ST_INIT_PCM    = 3'd3;
  localparam logic [2:0] ST_IDLE        = 3'd4;
  localparam logic [2:0] ST_VOL_MASTER  = 3'd5;
  localparam logic [2:0] ST_VOL_HEADPH  = 3'd6;
  localparam logic [2:0] ST_EXT         = 3'd7;

  localparam logic [6:0]  ADDR_MASTER = 7'h02;
  localparam logic [6:0]  ADDR_HEADPH = 7'h04;
  localparam logic [6:0]  ADDR_PCM    = 7'h18;
  localparam logic [15:0] PCM_WORD    = {3'b000, PCMOUT_GAIN, 3'b000, PCMOUT_GAIN};

  function automatic logic [15:0] vol_word(input logic [3:0] v);
    return {3'b000, 1'b1, v, 3'b000, 1'b1, v};
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  vol_cmd_q, vol_cmd_d;
  logic [3:0]  vol_applied_q, vol_applied_d;
  logic [3:0]  vol_new_q, vol_new_d;
  logic        vol_pend_q, vol_pend_d;
  logic        last_ext_q, last_ext_d;
  logic [6:0]  ext_addr_q, ext_addr_d;
  logic [15:0] ext_data_q, ext_data_d;
  logic        ext_ack_q, ext_ack_d;

  logic        w_consume;
  logic        w_post_init;
  logic        w_in_pair;
  logic [3:0]  w_vol_ref;
  logic [3:0]  w_vol_target;
  logic        w_vol_change;
  logic        w_ext_elig;
  logic        w_pick_ext;
  logic [6:0]  w_addr;
  logic [15:0] w_data;

  assign w_consume   = frame_start && cmd_valid;
  assign w_post_init = state_q[2];
  assign w_in_pair   = (state_q == ST_VOL_MASTER) || (state_q == ST_VOL_HEADPH);
  // While a pair is in flight, compare against the volume being written.
  assign w_vol_ref   = w_in_pair ? vol_cmd_q : vol_applied_q;
  // The ack cycle masks the still-held request that was just serviced.
  assign w_ext_elig  = ext_req && !ext_ack_q;
  assign w_pick_ext  = w_ext_elig && (!vol_pend_q || !last_ext_q);

`ifdef AC97_VOL_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]       db_vol_q;
  logic [CNT_W-1:0] db_cnt_q;

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      db_vol_q <= 4'h0;
      db_cnt_q <= '0;
    end else if (volume_control != db_vol_q) begin
      db_vol_q <= volume_control;
      db_cnt_q <= '0;
    end else if (frame_start && (db_cnt_q != CNT_MAX)) begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign w_vol_target = db_vol_q;
  assign w_vol_change = (db_cnt_q == CNT_MAX) && (db_vol_q != w_vol_ref);
`else
  assign w_vol_target = volume_control;
  assign w_vol_change = (volume_control != w_vol_ref);
`endif

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_WAIT_READY;
      vol_cmd_q     <= 4'h0;
      vol_applied_q <= 4'h0;
      vol_new_q     <= 4'h0;
      vol_pend_q    <= 1'b0;
      last_ext_q    <= 1'b0;
      ext_addr_q    <= 7'h00;
      ext_data_q    <= 16'h0000;
      ext_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vol_cmd_q     <= vol_cmd_d;
      vol_applied_q <= vol_applied_d;
      vol_new_q     <= vol_new_d;
      vol_pend_q    <= vol_pend_d;
      last_ext_q    <= last_ext_d;
      ext_addr_q    <= ext_addr_d;
      ext_data_q    <= ext_data_d;
      ext_ack_q     <= ext_ack_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vol_cmd_d     = vol_cmd_q;
    vol_applied_d = vol_applied_q;
    vol_new_d     = w_vol_change ? w_vol_target : vol_new_q;
    vol_pend_d    = w_post_init && w_vol_change;
    last_ext_d    = last_ext_q;
    ext_addr_d    = ext_addr_q;
    ext_data_d    = ext_data_q;
    ext_ack_d     = 1'b0;
    if ((state_q != ST_WAIT_READY) && !codec_ready) begin
      state_d = ST_WAIT_READY;
    end else begin
      case (state_q)
        ST_WAIT_READY: begin
          if (codec_ready) begin
            state_d   = ST_INIT_MASTER;
            vol_cmd_d = volume_control;
          end
        end
        ST_INIT_MASTER: if (w_consume) state_d = ST_INIT_HEADPH;
        ST_INIT_HEADPH: if (w_consume) state_d = ST_INIT_PCM;
        ST_INIT_PCM: begin
          if (w_consume) begin
            state_d       = ST_IDLE;
            vol_applied_d = vol_cmd_q;
          end
        end
        ST_IDLE: begin
          if (w_pick_ext) begin
            state_d    = ST_EXT;
            ext_addr_d = ext_addr;
            ext_data_d = ext_data;
            last_ext_d = 1'b1;
          end else if (vol_pend_q) begin
            state_d    = ST_VOL_MASTER;
            vol_cmd_d  = vol_new_q;
            last_ext_d = 1'b0;
          end
        end
        ST_VOL_MASTER: if (w_consume) state_d = ST_VOL_HEADPH;
        ST_VOL_HEADPH: begin
          if (w_consume) begin
            state_d       = ST_IDLE;
            vol_applied_d = vol_cmd_q;
          end
        end
        ST_EXT: begin
          if (w_consume) begin
            state_d   = ST_IDLE;
            ext_ack_d = 1'b1;
          end
        end
        default: state_d = ST_WAIT_READY;
      endcase
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    w_addr    = 7'h00;
    w_data    = 16'h0000;
    case (state_q)
      ST_INIT_MASTER, ST_VOL_MASTER: begin
        cmd_valid = 1'b1;
        w_addr    = ADDR_MASTER;
        w_data    = vol_word(vol_cmd_q);
      end
      ST_INIT_HEADPH, ST_VOL_HEADPH: begin
        cmd_valid = 1'b1;
        w_addr    = ADDR_HEADPH;
        w_data    = vol_word(vol_cmd_q);
      end
      ST_INIT_PCM: begin
        cmd_valid = 1'b1;
        w_addr    = ADDR_PCM;
        w_data    = PCM_WORD;
      end
      ST_EXT: begin
        cmd_valid = 1'b1;
        w_addr    = ext_addr_q;
        w_data    = ext_data_q;
      end
      default: ;
    endcase
  end

  assign cmd_addr  = {1'b0, w_addr, 12'h000};
  assign cmd_data  = {w_data, 4'h0};
  assign init_done = w_post_init;
  assign ext_ack   = ext_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ac97_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac97_cmd_sequencer
// Brief    : Scoreboard bench for ac97_cmd_sequencer (init, volume, external
//            writes, codec_ready loss, async reset, optional debounce).
// Revision : 1.0
// ============================================================================
module tb_ac97_cmd_sequencer;
  localparam int FRAME = 256;

  logic        bit_clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        frame_start = 1'b0;
  logic        codec_ready = 1'b0;
  logic [3:0]  volume_control = 4'h0;
  logic        ext_req = 1'b0;
  logic [6:0]  ext_addr = 7'h00;
  logic [15:0] ext_data = 16'h0000;
  logic        ext_ack, cmd_valid, init_done;
  logic [19:0] cmd_addr, cmd_data;

  typedef struct packed {
    logic [19:0] a;
    logic [19:0] d;
    logic        ext;
  } cmd_t;

  cmd_t sb_q[$];
  int   cons_frames[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   frame_no = 0;
  int   n_consumed = 0;
  logic ack_pipe = 1'b0;
  logic ack_exp = 1'b0;

  always #5 bit_clk = ~bit_clk;

  ac97_cmd_sequencer dut (
    .bit_clk        (bit_clk),
    .reset_b        (reset_b),
    .frame_start    (frame_start),
    .codec_ready    (codec_ready),
    .volume_control (volume_control),
    .ext_req        (ext_req),
    .ext_addr       (ext_addr),
    .ext_data       (ext_data),
    .ext_ack        (ext_ack),
    .cmd_valid      (cmd_valid),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .init_done      (init_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vw(input logic [3:0] v);
    return {4'b0001, v, 4'b0001, v};
  endfunction

  function automatic void exp_cmd(input logic [6:0] a, input logic [15:0] d, input logic ext);
    cmd_t e;
    e.a   = {1'b0, a, 12'h000};
    e.d   = {d, 4'h0};
    e.ext = ext;
    sb_q.push_back(e);
  endfunction

  // Serializer model: one-cycle frame_start every FRAME cycles.
  initial begin
    forever begin
      repeat (FRAME - 1) @(posedge bit_clk);
      #1 frame_start = 1'b1;
      @(posedge bit_clk);
      #1 frame_start = 1'b0;
    end
  end

  always @(negedge bit_clk) begin
    cmd_t e;
    ack_exp  = ack_pipe;
    ack_pipe = 1'b0;
    if (frame_start) frame_no++;
    if (!reset_b) begin
      ack_exp = 1'b0;
    end else begin
      if (ext_ack || ack_exp) check_val("ext_ack", 32'(ext_ack), 32'(ack_exp));
      if (frame_start && cmd_valid) begin
        check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val("cmd_addr", 32'(cmd_addr), 32'(e.a));
          check_val("cmd_data", 32'(cmd_data), 32'(e.d));
          if (e.ext) ack_pipe = 1'b1;
          if (e.a[18:12] == 7'h18) check_val("init_done_at_pcm", 32'(init_done), 32'd0);
        end
        cons_frames.push_back(frame_no);
        n_consumed++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bit_clk);
      #2;
    end
  endtask

  task automatic wait_consumed(input int target, input int budget);
    int i = 0;
    while ((n_consumed < target) && (i < budget)) begin
      tick(1);
      i++;
    end
    if (n_consumed < target) check_val("consume_timeout", 32'(n_consumed), 32'(target));
  endtask

  task automatic wait_ack(input int budget);
    int i = 0;
    while (!ext_ack && (i < budget)) begin
      tick(1);
      i++;
    end
    if (!ext_ack) check_val("ack_timeout", 32'(ext_ack), 32'd1);
  endtask

  task automatic wait_sb_empty(input int budget);
    int i = 0;
    while ((sb_q.size() != 0) && (i < budget)) begin
      tick(1);
      i++;
    end
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic sync_frame();
    int i = 0;
    while (!frame_start && (i < FRAME + 4)) begin
      tick(1);
      i++;
    end
    tick(1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    volume_control = 4'hF;
    tick(3);
    check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_val("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check_val("rst_cmd_data", 32'(cmd_data), 32'd0);
    check_val("rst_init_done", 32'(init_done), 32'd0);
    check_val("rst_ext_ack", 32'(ext_ack), 32'd0);
    reset_b = 1'b1;
    tick(4);
    check_val("wait_ready_no_cmd", 32'(cmd_valid), 32'd0);

    // Init sequence after codec_ready
    cons_frames.delete();
    exp_cmd(7'h02, 16'h1F1F, 1'b0);
    exp_cmd(7'h04, 16'h1F1F, 1'b0);
    exp_cmd(7'h18, 16'h0808, 1'b0);
    codec_ready = 1'b1;
    wait_consumed(3, 5 * FRAME);
    check_val("init_done_rise", 32'(init_done), 32'd1);
    if (cons_frames.size() == 3)
      check_val("init_frames", 32'(cons_frames[2] - cons_frames[0]), 32'd2);

    // Volume update pair
    base = n_consumed;
    volume_control = 4'h3;
    exp_cmd(7'h02, 16'h1313, 1'b0);
    exp_cmd(7'h04, 16'h1313, 1'b0);
    wait_sb_empty(12 * FRAME);
    tick(3 * FRAME);
    check_val("vol_pair_count", 32'(n_consumed - base), 32'd2);

`ifndef AC97_VOL_DEBOUNCE_EN
    // External write racing volume changes: round-robin order
    base = n_consumed;
    ext_addr = 7'h1A;
    ext_data = 16'h0404;
    ext_req  = 1'b1;
    volume_control = 4'h7;
    exp_cmd(7'h1A, 16'h0404, 1'b1);
    exp_cmd(7'h02, 16'h1717, 1'b0);
    exp_cmd(7'h04, 16'h1717, 1'b0);
    wait_ack(3 * FRAME);
    ext_addr = 7'h1B;
    ext_data = 16'h0505;
    exp_cmd(7'h1B, 16'h0505, 1'b1);
    wait_consumed(base + 2, 3 * FRAME);
    volume_control = 4'h9;
    exp_cmd(7'h02, 16'h1919, 1'b0);
    exp_cmd(7'h04, 16'h1919, 1'b0);
    wait_ack(4 * FRAME);
    ext_req = 1'b0;
    wait_sb_empty(4 * FRAME);
    tick(2 * FRAME);
    check_val("rr_count", 32'(n_consumed - base), 32'd6);
`endif

    // Async reset while a command is presented, then ext_req held through init
    sync_frame();
    volume_control = 4'hA;
    tick(5);
`ifndef AC97_VOL_DEBOUNCE_EN
    check_val("pair_presented", 32'(cmd_valid), 32'd1);
`endif
    #1 reset_b = 1'b0;
    #1;
    check_val("areset_valid", 32'(cmd_valid), 32'd0);
    check_val("areset_init_done", 32'(init_done), 32'd0);
    check_val("areset_addr", 32'(cmd_addr), 32'd0);
    sb_q.delete();
    codec_ready = 1'b0;
    ext_addr = 7'h2C;
    ext_data = 16'h1234;
    ext_req  = 1'b1;
    volume_control = 4'hC;
    tick(3);
    reset_b = 1'b1;
    tick(20);
    check_val("held_init_done", 32'(init_done), 32'd0);
    cons_frames.delete();
    exp_cmd(7'h02, 16'h1C1C, 1'b0);
    exp_cmd(7'h04, 16'h1C1C, 1'b0);
    exp_cmd(7'h18, 16'h0808, 1'b0);
    exp_cmd(7'h2C, 16'h1234, 1'b1);
    codec_ready = 1'b1;
    wait_ack(6 * FRAME);
    ext_req = 1'b0;
    wait_sb_empty(2 * FRAME);
    if (cons_frames.size() == 4)
      check_val("ext_first_idle_frame", 32'(cons_frames[3] - cons_frames[2]), 32'd1);

    // codec_ready loss in IDLE and mid-init
    base = n_consumed;
    sync_frame();
    codec_ready = 1'b0;
    tick(2);
    check_val("drop_idle_init_done", 32'(init_done), 32'd0);
    codec_ready = 1'b1;
    exp_cmd(7'h02, 16'h1C1C, 1'b0);
    wait_consumed(base + 1, 2 * FRAME);
    codec_ready = 1'b0;
    tick(1);
    check_val("drop_mid_valid", 32'(cmd_valid), 32'd0);
    check_val("drop_mid_init_done", 32'(init_done), 32'd0);
    volume_control = 4'h5;
    tick(10);
    exp_cmd(7'h02, 16'h1515, 1'b0);
    exp_cmd(7'h04, 16'h1515, 1'b0);
    exp_cmd(7'h18, 16'h0808, 1'b0);
    codec_ready = 1'b1;
    wait_sb_empty(5 * FRAME);
    check_val("reinit_done", 32'(init_done), 32'd1);

`ifdef AC97_VOL_DEBOUNCE_EN
    // Debounce: short-lived values are ignored, a held value is applied once
    base = n_consumed;
    for (int i = 0; i < 4; i++) begin
      volume_control = (i % 2 == 0) ? 4'h3 : 4'h6;
      tick(2 * FRAME);
    end
    check_val("debounce_no_update", 32'(n_consumed - base), 32'd0);
    volume_control = 4'h9;
    exp_cmd(7'h02, 16'h1919, 1'b0);
    exp_cmd(7'h04, 16'h1919, 1'b0);
    wait_sb_empty(9 * FRAME);
    tick(FRAME);
    check_val("debounce_pair", 32'(n_consumed - base), 32'd2);
`endif

    tick(FRAME);
    check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
